// File: rtl/reflet_uart_pkg.sv
// Shared UART definitions: receiver FSM state encoding and bit-timing helpers.
// The timing helpers are also used by the testbench's serial sender model.
package reflet_uart_pkg;

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StStart  = 3'd1;
  localparam logic [2:0] StData   = 3'd2;
  localparam logic [2:0] StParity = 3'd3;
  localparam logic [2:0] StStop   = 3'd4;

  // Clock cycles per bit, integer-truncated.
  function automatic int unsigned uart_div(input int unsigned clk_freq,
                                           input int unsigned baud_rate);
    return clk_freq / baud_rate;
  endfunction

  // Cycles from a detected start edge to the middle of the start bit.
  function automatic int unsigned uart_half(input int unsigned clk_freq,
                                            input int unsigned baud_rate);
    return uart_div(clk_freq, baud_rate) / 2;
  endfunction

endpackage

// File: rtl/reflet_fifo.sv
// Parameterised show-ahead synchronous FIFO. The head entry is presented on
// rdata_o whenever the FIFO is not empty (zero otherwise). A push while full is
// accepted only if a pop happens in the same cycle; a pop while empty is ignored.
module reflet_fifo #(
  parameter int unsigned Width     = 8,
  parameter int unsigned DepthLog2 = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 push_i,
  input  logic [Width-1:0]     wdata_i,
  input  logic                 pop_i,
  output logic [Width-1:0]     rdata_o,
  output logic                 full_o,
  output logic                 empty_o,
  output logic [DepthLog2:0]   fill_o
);

  localparam int unsigned Depth = 1 << DepthLog2;

  logic [Width-1:0]     mem_q [Depth];
  logic [DepthLog2-1:0] wptr_q, wptr_d;
  logic [DepthLog2-1:0] rptr_q, rptr_d;
  logic [DepthLog2:0]   fill_q, fill_d;
  logic                 do_push, do_pop;

  // Occupancy never exceeds Depth, so the MSB alone marks full.
  assign full_o  = fill_q[DepthLog2];
  assign empty_o = (fill_q == '0);
  assign fill_o  = fill_q;

  // Qualify requests and compute next pointers/occupancy.
  always_comb begin
    do_pop  = pop_i & ~empty_o;
    do_push = push_i & (~full_o | do_pop);
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    fill_d  = fill_q;
    if (do_push) wptr_d = wptr_q + 1'b1;
    if (do_pop)  rptr_d = rptr_q + 1'b1;
    unique case ({do_push, do_pop})
      2'b10:   fill_d = fill_q + 1'b1;
      2'b01:   fill_d = fill_q - 1'b1;
      default: fill_d = fill_q;
    endcase
  end

  // Head output; zero while empty so the port is clean out of reset.
  always_comb begin
    rdata_o = '0;
    if (!empty_o) rdata_o = mem_q[rptr_q];
  end

  // Pointer and occupancy state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      fill_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      fill_q <= fill_d;
    end
  end

  // Storage array, no reset needed: contents are only visible when occupied.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/reflet_uart_rx.sv
// Buffered UART receiver: 2-flop synchroniser, mid-bit sampling FSM, show-ahead
// FIFO and sticky error flags. Frame is 8N1 by default; defining
// REFLET_UART_RX_PARITY_EN selects 8E1 and adds the parity_err output.
module reflet_uart_rx
  import reflet_uart_pkg::*;
#(
  parameter int unsigned clk_freq        = 1_000_000,
  parameter int unsigned baud_rate       = 9600,
  parameter int unsigned fifo_depth_log2 = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       rx,
  output logic [7:0]                 data_out,
  output logic                       data_valid,
  input  logic                       data_read,
  output logic                       overflow,
  output logic                       framing_err,
  input  logic                       err_clear,
  output logic [fifo_depth_log2:0]   fill
`ifdef REFLET_UART_RX_PARITY_EN
  ,
  output logic                       parity_err
`endif
);

  localparam int unsigned Div  = uart_div(clk_freq, baud_rate);
  localparam int unsigned Half = uart_half(clk_freq, baud_rate);
  localparam int unsigned CntW = $clog2(Div);
  // The counter expires on zero, so a load of N-1 gives an N-cycle interval.
  localparam logic [CntW-1:0] DivM1  = CntW'(Div - 1);
  localparam logic [CntW-1:0] HalfM1 = CntW'(Half - 1);

  logic            rx_meta_q, rxs_q;
  logic [2:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            wait_high_q, wait_high_d;
  logic            overflow_q, overflow_d;
  logic            framing_err_q, framing_err_d;
  logic            expired, push, frame_evt, ovf_evt;
  logic            fifo_full, fifo_empty;
`ifdef REFLET_UART_RX_PARITY_EN
  logic            par_bad_q, par_bad_d;
  logic            parity_err_q, parity_err_d;
  logic            par_evt;
`endif

  // Frame decoder: mid-bit sampling driven by a single down-counter.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    wait_high_d = wait_high_q & ~rxs_q;
    push        = 1'b0;
    frame_evt   = 1'b0;
`ifdef REFLET_UART_RX_PARITY_EN
    par_bad_d   = par_bad_q;
    par_evt     = 1'b0;
`endif
    expired = (cnt_q == '0);
    if (state_q != StIdle && !expired) cnt_d = cnt_q - 1'b1;

    case (state_q)
      StIdle: begin
        // After a framing error the line must go high before a new start.
        if (!rxs_q && !wait_high_q) begin
          state_d = StStart;
          cnt_d   = HalfM1;
        end
      end
      StStart: begin
        if (expired) begin
          if (rxs_q) begin
            state_d = StIdle;
          end else begin
            state_d = StData;
            cnt_d   = DivM1;
            bit_d   = 3'd0;
          end
        end
      end
      StData: begin
        if (expired) begin
          shift_d = {rxs_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          cnt_d   = DivM1;
          if (bit_q == 3'd7) begin
`ifdef REFLET_UART_RX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end
        end
      end
`ifdef REFLET_UART_RX_PARITY_EN
      StParity: begin
        if (expired) begin
          // Even parity: data bits plus parity bit must XOR to zero.
          par_bad_d = rxs_q ^ (^shift_q);
          par_evt   = rxs_q ^ (^shift_q);
          cnt_d     = DivM1;
          state_d   = StStop;
        end
      end
`endif
      StStop: begin
        if (expired) begin
          state_d = StIdle;
          if (rxs_q) begin
`ifdef REFLET_UART_RX_PARITY_EN
            push = ~par_bad_q;
`else
            push = 1'b1;
`endif
          end else begin
            frame_evt   = 1'b1;
            wait_high_d = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Sticky flags: a new event wins over a simultaneous clear.
  always_comb begin
    ovf_evt       = push & fifo_full & ~(data_read & ~fifo_empty);
    overflow_d    = ovf_evt | (overflow_q & ~err_clear);
    framing_err_d = frame_evt | (framing_err_q & ~err_clear);
`ifdef REFLET_UART_RX_PARITY_EN
    parity_err_d  = par_evt | (parity_err_q & ~err_clear);
`endif
  end

  // Synchroniser, decoder and flag state.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_q     <= 1'b1;
      rxs_q         <= 1'b1;
      state_q       <= StIdle;
      cnt_q         <= '0;
      bit_q         <= '0;
      shift_q       <= '0;
      wait_high_q   <= 1'b0;
      overflow_q    <= 1'b0;
      framing_err_q <= 1'b0;
    end else begin
      rx_meta_q     <= rx;
      rxs_q         <= rx_meta_q;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      bit_q         <= bit_d;
      shift_q       <= shift_d;
      wait_high_q   <= wait_high_d;
      overflow_q    <= overflow_d;
      framing_err_q <= framing_err_d;
    end
  end

`ifdef REFLET_UART_RX_PARITY_EN
  // Parity check result and its sticky flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      par_bad_q    <= par_bad_d;
      parity_err_q <= parity_err_d;
    end
  end

  assign parity_err = parity_err_q;
`endif

  reflet_fifo #(
    .Width     (8),
    .DepthLog2 (fifo_depth_log2)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (reset),
    .push_i  (push),
    .wdata_i (shift_q),
    .pop_i   (data_read),
    .rdata_o (data_out),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .fill_o  (fill)
  );

  assign data_valid  = ~fifo_empty;
  assign overflow    = overflow_q;
  assign framing_err = framing_err_q;

endmodule

// File: tb/tb_reflet_uart_rx.sv
// Self-checking bench for reflet_uart_rx: a serial sender model schedules the
// expected FIFO/flag events per frame; a reference model replays them each cycle
// and a compare process checks every DUT output on every falling clock edge.
module tb_reflet_uart_rx;
  import reflet_uart_pkg::*;

  localparam int unsigned ClkFreq = 1_000_000;
  localparam int unsigned Baud    = 9600;
  localparam int unsigned Log2    = 4;
  localparam int Depth = 1 << Log2;
  localparam int Div   = int'(uart_div(ClkFreq, Baud));
  localparam int Half  = int'(uart_half(ClkFreq, Baud));
`ifdef REFLET_UART_RX_PARITY_EN
  localparam int NFrame = 11;
  localparam int LatPar = 2 + Half + 9 * Div;
`else
  localparam int NFrame = 10;
`endif
  // Edges from the first edge that sees the start bit to the push edge.
  localparam int Lat = 2 + Half + (NFrame - 1) * Div;

  logic         clk, reset, rx, data_read, err_clear;
  logic [7:0]   data_out;
  logic         data_valid, overflow, framing_err;
  logic [Log2:0] fill;
`ifdef REFLET_UART_RX_PARITY_EN
  logic         parity_err;
`endif

  reflet_uart_rx #(
    .clk_freq        (ClkFreq),
    .baud_rate       (Baud),
    .fifo_depth_log2 (Log2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rx          (rx),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .data_read   (data_read),
    .overflow    (overflow),
    .framing_err (framing_err),
    .err_clear   (err_clear),
    .fill        (fill)
`ifdef REFLET_UART_RX_PARITY_EN
    ,
    .parity_err  (parity_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    bit         push;
    bit         fe;
    bit         pe;
    logic [7:0] d;
  } ev_t;

  ev_t        ev_q[$];
  logic [7:0] mq[$];
  bit         m_ovf, m_fe, m_pe;
  int         cyc;
  int         total, bad;
  bit         chk_en;
  ev_t        e_m;
  bit         pop_m, s_ovf, s_fe, s_pe;
  logic [7:0] rb;
  bit         rst_ok, rpk, rnd_done;

  task automatic chk(input string nm, input logic [31:0] act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: FIFO as a queue, flags as bits, events applied on their edge.
  initial begin
    cyc = 0;
    m_ovf = 0; m_fe = 0; m_pe = 0;
    forever begin
      @(posedge clk);
      cyc++;
      if (reset) begin
        mq.delete();
        ev_q.delete();
        m_ovf = 0; m_fe = 0; m_pe = 0;
      end else begin
        pop_m = data_read && (mq.size() != 0);
        s_ovf = 0; s_fe = 0; s_pe = 0;
        if (pop_m) void'(mq.pop_front());
        while (ev_q.size() != 0 && ev_q[0].cyc == cyc) begin
          e_m = ev_q.pop_front();
          if (e_m.fe) s_fe = 1;
          if (e_m.pe) s_pe = 1;
          if (e_m.push) begin
            if (mq.size() == Depth) s_ovf = 1;
            else mq.push_back(e_m.d);
          end
        end
        m_ovf = s_ovf | (m_ovf & !err_clear);
        m_fe  = s_fe | (m_fe & !err_clear);
        m_pe  = s_pe | (m_pe & !err_clear);
      end
    end
  end

  // Compare every output against the model on each falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("valid", data_valid, int'(mq.size() != 0));
        chk("data", data_out, (mq.size() != 0) ? int'(mq[0]) : 0);
        chk("fill", fill, mq.size());
        chk("overflow", overflow, int'(m_ovf));
        chk("framing_err", framing_err, int'(m_fe));
`ifdef REFLET_UART_RX_PARITY_EN
        chk("parity_err", parity_err, int'(m_pe));
`endif
      end
    end
  end

  // Serial sender; call on a falling edge. Schedules the frame's expected events.
  task automatic send_byte(input logic [7:0] b, input bit stop_ok, input bit par_ok);
    logic [10:0] fr;
    ev_t         e;
    fr      = '1;
    fr[0]   = 1'b0;
    fr[8:1] = b;
`ifdef REFLET_UART_RX_PARITY_EN
    fr[9]  = par_ok ? ^b : ~^b;
    fr[10] = stop_ok;
    if (!par_ok) begin
      e = '{cyc: cyc + 1 + LatPar, push: 1'b0, fe: 1'b0, pe: 1'b1, d: 8'h00};
      ev_q.push_back(e);
    end
`else
    fr[9] = stop_ok;
`endif
    e = '{cyc: cyc + 1 + Lat, push: stop_ok && par_ok, fe: !stop_ok, pe: 1'b0, d: b};
    ev_q.push_back(e);
    for (int i = 0; i < NFrame; i++) begin
      rx = fr[i];
      repeat (Div) @(negedge clk);
    end
    rx = 1'b1;
    // A low stop bit needs the line high again before the next start.
    if (!stop_ok) repeat (Div) @(negedge clk);
  endtask

  // Check the head byte then pop it; returns one cycle later.
  task automatic pop_expect(input int exp);
    chk("pop_data", data_out, exp);
    data_read = 1'b1;
    @(negedge clk);
    data_read = 1'b0;
  endtask

  task automatic clear_flags();
    err_clear = 1'b1;
    @(negedge clk);
    err_clear = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    total = 0; bad = 0; chk_en = 0;
    rx = 1'b1; reset = 1'b1; data_read = 1'b0; err_clear = 1'b0;
    repeat (3) @(negedge clk);
    chk_en = 1;
    chk("rst_valid", data_valid, 0);
    chk("rst_data", data_out, 0);
    chk("rst_fill", fill, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_framing", framing_err, 0);
    reset = 1'b0;
    @(negedge clk);

    // Single byte with exact push latency.
    fork
      send_byte(8'hA5, 1'b1, 1'b1);
      begin
        repeat (Lat) @(negedge clk);
        chk("lat_early_valid", data_valid, 0);
        @(negedge clk);
        chk("lat_valid", data_valid, 1);
        chk("lat_data", data_out, 8'hA5);
        chk("lat_fill", fill, 1);
      end
    join
    pop_expect(8'hA5);
    chk("pop_empty", data_valid, 0);

    // Seventeen bytes, no reads: last one dropped.
    for (int i = 0; i <= 16; i++) send_byte(8'(i), 1'b1, 1'b1);
    chk("ovf_fill", fill, 16);
    chk("ovf_flag", overflow, 1);
    for (int i = 0; i < 16; i++) pop_expect(i);
    chk("ovf_drained", data_valid, 0);
    clear_flags();
    chk("ovf_cleared", overflow, 0);

    // Full FIFO with a pop on the push edge: no overflow.
    for (int i = 0; i < 16; i++) send_byte(8'(8'h40 + i), 1'b1, 1'b1);
    fork
      send_byte(8'hE7, 1'b1, 1'b1);
      begin
        repeat (Lat) @(negedge clk);
        data_read = 1'b1;
        @(negedge clk);
        data_read = 1'b0;
      end
    join
    chk("full_rw_overflow", overflow, 0);
    chk("full_rw_fill", fill, 16);
    for (int i = 1; i < 16; i++) pop_expect(8'h40 + i);
    pop_expect(8'hE7);

    // Framing error, clear, then a good frame.
    send_byte(8'h3C, 1'b0, 1'b1);
    chk("fe_flag", framing_err, 1);
    chk("fe_fill", fill, 0);
    clear_flags();
    chk("fe_cleared", framing_err, 0);
    send_byte(8'h3C, 1'b1, 1'b1);
    chk("fe_next_fill", fill, 1);
    pop_expect(8'h3C);

    // Short low glitch: ignored.
    rx = 1'b0;
    repeat (20) @(negedge clk);
    rx = 1'b1;
    repeat (100) @(negedge clk);
    chk("glitch_fill", fill, 0);
    chk("glitch_framing", framing_err, 0);

    // Reset in the middle of a frame.
    send_byte(8'h11, 1'b1, 1'b1);
    send_byte(8'h22, 1'b0, 1'b1);
    rx = 1'b0;
    repeat (4 * Div) @(negedge clk);
    reset = 1'b1;
    rx = 1'b1;
    @(negedge clk);
    chk("midrst_fill", fill, 0);
    chk("midrst_valid", data_valid, 0);
    chk("midrst_framing", framing_err, 0);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    send_byte(8'h96, 1'b1, 1'b1);
    chk("postrst_fill", fill, 1);
    pop_expect(8'h96);

`ifdef REFLET_UART_RX_PARITY_EN
    // 0x07 has odd weight: parity bit must be 1.
    send_byte(8'h07, 1'b1, 1'b0);
    chk("par_flag", parity_err, 1);
    chk("par_fill", fill, 0);
    clear_flags();
    send_byte(8'h07, 1'b1, 1'b1);
    chk("par_ok_fill", fill, 1);
    pop_expect(8'h07);
`endif

    // Random frames with random reads and clears.
    rnd_done = 0;
    fork
      begin
        for (int k = 0; k < 15; k++) begin
          rb     = 8'($urandom);
          rst_ok = ($urandom_range(0, 7) != 0);
`ifdef REFLET_UART_RX_PARITY_EN
          rpk = ($urandom_range(0, 7) != 0);
`else
          rpk = 1'b1;
`endif
          send_byte(rb, rst_ok, rpk);
          repeat ($urandom_range(0, 150)) @(negedge clk);
        end
        rnd_done = 1;
      end
      begin
        while (!rnd_done) begin
          @(negedge clk);
          data_read = ($urandom_range(0, 3) == 0);
          err_clear = ($urandom_range(0, 40) == 0);
        end
        data_read = 1'b0;
        err_clear = 1'b0;
      end
    join
    repeat (20) begin
      data_read = 1'b1;
      @(negedge clk);
    end
    data_read = 1'b0;
    @(negedge clk);
    chk("final_empty", data_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reflet_uart_rx.md
# reflet_uart_rx

Buffered UART receiver for the Reflet microcontroller: the stage directly downstream of the serial `rx` pin. It deserialises 8-bit frames sent by an external transmitter (the bench's UART sender model) and queues them in a small show-ahead FIFO. The CPU-facing peripheral pops bytes from that FIFO. Framing, overflow and optional parity errors are reported as sticky flags.

## Interface
- `clk_freq`, 1_000_000: system clock frequency in Hz.
- `baud_rate`, 9600: line rate in baud.
- `fifo_depth_log2`, 4: FIFO holds 2^n bytes (16 by default).
- `clk`  input  1  system clock, rising edge.
- `reset`  input  1  reset; synchronous, active-high.
- `rx`  input  1  asynchronous serial line, idle high.
- `data_out`  output  8  FIFO head byte; valid only while `data_valid`=1.
- `data_valid`  output  1  FIFO not empty.
- `data_read`  input  1  pop request; ignored when `data_valid`=0.
- `overflow`  output  1  sticky: a complete byte was dropped because the FIFO was full.
- `framing_err`  output  1  sticky: stop bit sampled low.
- `err_clear`  input  1  clears all sticky flags.
- `fill`  output  fifo_depth_log2+1  current FIFO occupancy.

## Operation
- Bit period `DIV = clk_freq / baud_rate`, integer-truncated; 104 cycles at the defaults. `HALF = DIV/2`.
- `rx` passes through a 2-flop synchroniser. All decoding uses the synchronised value `rxs`.
- FSM:
  - IDLE: when `rxs`=0, load the counter with `HALF`, go to START.
  - START: at counter expiry, if `rxs`=1 it was a glitch, return to IDLE with no flag. Otherwise reload `DIV` and go to DATA.
  - DATA: sample `rxs` at each expiry, LSB first. After 8 bits go to STOP, or to PARITY when that feature is compiled in.
  - STOP: at expiry, if `rxs`=1, push the byte. If `rxs`=0, set `framing_err` and discard the byte. Go to IDLE. A line held low then re-triggers START only after `rxs` has returned high.
- The bit counter is 3 bits wide and wraps; the DATA→STOP exit is decoded on count 7 at expiry.
- FIFO:
  - Push with `fill`=2^n and no simultaneous pop: the byte is dropped and `overflow` is set.
  - Push and pop in the same cycle while full: both happen, no overflow, `fill` is unchanged.
  - Push and pop in the same cycle while empty: only the push happens.
  - Read and write pointers are n bits and wrap naturally.
- Sticky flags: set has priority over `err_clear` in the same cycle.
- `reset` aborts any frame in progress and empties the FIFO. Bits already received are discarded.

## Timing
- Reset values: `data_out`=0, `data_valid`=0, `overflow`=0, `framing_err`=0, `fill`=0. The FSM is in IDLE.
- Latency: the push happens on the mid-stop-bit sample, 2 + HALF + 9·DIV cycles after the `rx` falling edge (one more DIV with parity).
- `data_valid` rises on the clock edge after the push cycle.
- `data_read` with `data_valid`=1: the head advances on that edge. `data_out` shows the next byte the following cycle with no bubble, and `fill` decrements.
- Flags update on the edge after the detecting sample.
- Throughput: back-to-back frames with one stop bit are accepted. The FSM is in IDLE before the next start edge arrives.

## Configuration
- `REFLET_UART_RX_PARITY_EN` defined:
  - The frame is 8E1; an even parity bit is sampled in a PARITY state between DATA and STOP.
  - On mismatch, the `parity_err` sticky output (1 bit, reset 0, cleared by `err_clear`) is set and the byte is discarded.
  - The port list grows by `parity_err`.
- Not defined: the frame is 8N1, with no PARITY state and no `parity_err` port.

## Structure
- Shared package `reflet_uart_pkg`: FSM state encoding (IDLE, START, DATA, PARITY, STOP) and the `DIV`/`HALF` computation function. The bench's UART sender model reuses the same function.
- Sub-module `reflet_fifo`: a parameterised show-ahead synchronous FIFO with push/pop/full/empty/fill. It has no UART knowledge and is reusable by the TX side.

## Test plan
- Reset, then send 0xA5 at 9600 baud → after 2+52+9·104 cycles, `data_valid`=1, `data_out`=0xA5, `fill`=1; after `data_read`, `data_valid`=0.
- Send 17 bytes 0x00..0x10 with no reads → `fill`=16 and `overflow`=1; pops return 0x00..0x0F in order, and 0x10 is lost.
- Full FIFO, `data_read` held during the 17th byte's push cycle → no overflow; `fill` stays at 16 and the last pop returns the new byte.
- Frame 0x3C with stop bit forced low → `framing_err`=1 and `fill` unchanged; `err_clear` pulse → 0; a following valid 0x3C is queued.
- 20-cycle low glitch on `rx` → nothing queued, no flags set. `reset` asserted mid-frame → all outputs return to zero and the next full frame is received correctly.
- With `REFLET_UART_RX_PARITY_EN`: 0x07 sent with parity bit 0 → `parity_err`=1, byte discarded; sent with parity bit 1 → queued as 0x07.
